// File: rtl/lookup3_pkg.sv
// Shared constants, FSM state codes and rotate helper for the lookup3 absorb stage.
package lookup3_pkg;

    localparam logic [31:0] LOOKUP3_INIT = 32'hDEADBEEF;

    localparam logic [4:0] ROT_S0 = 5'd4;
    localparam logic [4:0] ROT_S1 = 5'd6;
    localparam logic [4:0] ROT_S2 = 5'd8;
    localparam logic [4:0] ROT_S3 = 5'd16;
    localparam logic [4:0] ROT_S4 = 5'd19;
    localparam logic [4:0] ROT_S5 = 5'd4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] MIX  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    function automatic logic [31:0] rot32(input logic [31:0] x, input logic [4:0] k);
        return (x << k) | (x >> (6'd32 - {1'b0, k}));
    endfunction

endpackage

// File: rtl/lookup3_mix_step.sv
// One lookup3 mix sub-step: x' = (x - z) ^ rot(z, shift), z' = z + y.
module lookup3_mix_step
    import lookup3_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic [4:0]  shift,
    output logic [31:0] x_next,
    output logic [31:0] z_next
);

    assign x_next = (x - z) ^ rot32(z, shift);
    assign z_next = z + y;

endmodule

// File: rtl/lookup3_absorb.sv
// lookup3 hashlittle absorb stage: seeds a/b/c, adds 12-byte blocks, mixes between them.
//
// state | meaning
// IDLE  | waiting for start; seeds a/b/c from len and initval
// LOAD  | accepting key words into a, b, c in turn
// MIX   | six mix sub-steps between full blocks, input stalled
// OUT   | final triple presented until downstream accepts
module lookup3_absorb
    import lookup3_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      initval,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [31:0]      out_c,
    output logic             out_skip
);

    logic [1:0]       state;
    logic [31:0]      a, b, c;
    logic [LEN_W-2:0] words_left;
    logic [1:0]       idx;
    logic [2:0]       step;
    logic [1:0]       len_lo;
    logic             skip;

    logic             last_word;
    logic [31:0]      tail_mask;
    logic [31:0]      word;
    logic [31:0]      seed;
    logic [LEN_W-2:0] nwords;
    logic [31:0]      mx, my, mz, mx_next, mz_next;
    logic [4:0]       mshift;

    assign last_word = (words_left == (LEN_W-1)'(1));
    assign seed      = LOOKUP3_INIT + 32'(len) + initval;
    assign nwords    = {1'b0, len[LEN_W-1:2]} + (LEN_W-1)'(len[1:0] != 2'b00);

    always_comb begin
        tail_mask = 32'hFFFFFFFF;
        case (len_lo)
            2'd1:    tail_mask = 32'h000000FF;
            2'd2:    tail_mask = 32'h0000FFFF;
            2'd3:    tail_mask = 32'h00FFFFFF;
            default: tail_mask = 32'hFFFFFFFF;
        endcase
        word = last_word ? (in_data & tail_mask) : in_data;
    end

    // Each sub-step is the same kernel on a rotated view of (a, b, c).
    always_comb begin
        mx     = a;
        my     = b;
        mz     = c;
        mshift = ROT_S0;
        case (step)
            3'd0, 3'd3: begin mx = a; my = b; mz = c; end
            3'd1, 3'd4: begin mx = b; my = c; mz = a; end
            3'd2, 3'd5: begin mx = c; my = a; mz = b; end
            default:    begin mx = a; my = b; mz = c; end
        endcase
        case (step)
            3'd0:    mshift = ROT_S0;
            3'd1:    mshift = ROT_S1;
            3'd2:    mshift = ROT_S2;
            3'd3:    mshift = ROT_S3;
            3'd4:    mshift = ROT_S4;
            3'd5:    mshift = ROT_S5;
            default: mshift = ROT_S0;
        endcase
    end

    lookup3_mix_step u_mix_step (
        .x      (mx),
        .y      (my),
        .z      (mz),
        .shift  (mshift),
        .x_next (mx_next),
        .z_next (mz_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            words_left <= '0;
            idx        <= '0;
            step       <= '0;
            len_lo     <= '0;
            skip       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a      <= seed;
                        b      <= seed;
                        c      <= seed;
                        len_lo <= len[1:0];
                        idx    <= '0;
                        if (len == '0) begin
                            skip  <= 1'b1;
                            state <= OUT;
                        end else begin
                            words_left <= nwords;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        case (idx)
                            2'd0:    a <= a + word;
                            2'd1:    b <= b + word;
                            default: c <= c + word;
                        endcase
                        words_left <= words_left - (LEN_W-1)'(1);
                        idx        <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                        if (last_word) begin
                            state <= OUT;
                        end else if (idx == 2'd2) begin
                            state <= MIX;
                            step  <= '0;
                        end
                    end
                end
                MIX: begin
                    case (step)
                        3'd0, 3'd3: begin a <= mx_next; c <= mz_next; end
                        3'd1, 3'd4: begin b <= mx_next; a <= mz_next; end
                        3'd2, 3'd5: begin c <= mx_next; b <= mz_next; end
                        default:    ;
                    endcase
                    if (step == 3'd5) begin
                        state <= LOAD;
                        idx   <= '0;
                        step  <= '0;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                        skip  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == OUT);
    assign out_a     = a;
    assign out_b     = b;
    assign out_c     = c;
    assign out_skip  = skip;

endmodule

// File: tb/tb_lookup3_absorb.sv
// Randomised bench for lookup3_absorb against a byte-level hashlittle reference model.
module tb_lookup3_absorb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] len;
    logic [31:0] initval;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b, out_c;
    logic        out_skip;

    int total = 0;
    int bad   = 0;

    logic [7:0]  kb [0:127];
    logic [96:0] exp_q [$];

    always #5 clk = ~clk;

    lookup3_absorb #(.LEN_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .initval   (initval),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_skip  (out_skip)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    task automatic mix(inout logic [31:0] a, inout logic [31:0] b, inout logic [31:0] c);
        a -= c; a ^= rotl(c, 4);  c += b;
        b -= a; b ^= rotl(a, 6);  a += c;
        c -= b; c ^= rotl(b, 8);  b += a;
        a -= c; a ^= rotl(c, 16); c += b;
        b -= a; b ^= rotl(a, 19); a += c;
        c -= b; c ^= rotl(b, 4);  b += a;
    endtask

    // Little-endian word at byte offset p; bytes at or past the key length read as zero.
    function automatic logic [31:0] kw(input int unsigned l, input int unsigned p);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++)
            if (p + i < l) w |= 32'(kb[p + i]) << (8 * i);
        return w;
    endfunction

    task automatic model(input int unsigned l, input logic [31:0] iv,
                         output logic [31:0] a, output logic [31:0] b,
                         output logic [31:0] c, output logic sk);
        int unsigned rem;
        int unsigned p;
        a  = 32'hDEADBEEF + l + iv;
        b  = a;
        c  = a;
        sk = (l == 0);
        if (l != 0) begin
            rem = l;
            p   = 0;
            while (rem > 12) begin
                a += kw(l, p); b += kw(l, p + 4); c += kw(l, p + 8);
                mix(a, b, c);
                rem -= 12;
                p   += 12;
            end
            a += kw(l, p); b += kw(l, p + 4); c += kw(l, p + 8);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One output compare process: every cycle out_valid is high the triple must match the head.
    always @(negedge clk) begin
        logic [96:0] e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q[0];
                check("out_a", out_a, e[95:64]);
                check("out_b", out_b, e[63:32]);
                check("out_c", out_c, e[31:0]);
                check("out_skip", {31'd0, out_skip}, {31'd0, e[96]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic feed_word(input int i, input bit gap, output int waits);
        in_data = {kb[4*i+3], kb[4*i+2], kb[4*i+1], kb[4*i]};
        if (gap) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        check("word_accept", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_key(input int unsigned l, input logic [31:0] iv, input int bp,
                           input bit gaps, input bit pulse);
        logic [31:0] ea, eb, ec;
        logic        es;
        int          nw, w, guard;
        model(l, iv, ea, eb, ec, es);
        exp_q.push_back({es, ea, eb, ec});
        check("idle_before_start", {31'd0, busy}, 32'd0);
        start   = 1'b1;
        len     = l;
        initval = iv;
        step();
        start   = 1'b0;
        len     = $urandom;
        initval = $urandom;
        nw = (l + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            feed_word(i, gaps && ($urandom_range(0, 3) == 0), w);
            if (!gaps) check("mix_bubble", w, (i > 0 && i % 3 == 0) ? 32'd6 : 32'd0);
        end
        @(negedge clk);
        check("out_valid_latency", {31'd0, out_valid}, 32'd1);
        check("in_ready_low_in_out", {31'd0, in_ready}, 32'd0);
        guard = 0;
        while (!out_valid && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        for (int k = 0; k < bp; k++) begin
            step();
            start = pulse && (k % 3 == 0);
            len   = 32'd7;
        end
        step();
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_accept", {31'd0, busy}, 32'd0);
        check("out_valid_dropped", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ma, mb, mc;
        logic        ms;
        int          w;

        rst = 1'b1; start = 1'b0; len = '0; initval = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_skip", {31'd0, out_skip}, 32'd0);
        rst = 1'b0;
        step();

        // Empty key: seed only, skip flagged.
        model(0, 32'd0, ma, mb, mc, ms);
        check("pin0_a", ma, 32'hDEADBEEF);
        check("pin0_c", mc, 32'hDEADBEEF);
        check("pin0_skip", {31'd0, ms}, 32'd1);
        run_key(0, 32'd0, 3, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) kb[i] = 8'hFF;
        model(1, 32'd0, ma, mb, mc, ms);
        check("pin1_a", ma, 32'hDEADBFEF);
        check("pin1_b", mb, 32'hDEADBEF0);
        check("pin1_skip", {31'd0, ms}, 32'd0);
        run_key(1, 32'd0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) kb[i] = 8'h00;
        kb[0] = 8'd1; kb[4] = 8'd2; kb[8] = 8'd3;
        model(12, 32'd0, ma, mb, mc, ms);
        check("pin12_a", ma, 32'hDEADBEFC);
        check("pin12_b", mb, 32'hDEADBEFD);
        check("pin12_c", mc, 32'hDEADBEFE);
        run_key(12, 32'd0, 0, 1'b0, 1'b0);

        // 13 bytes: one mix then a one-byte tail; also long backpressure with start pulses.
        for (int i = 0; i < 16; i++) kb[i] = (i < 13) ? 8'(i) : 8'h00;
        run_key(13, 32'd0, 10, 1'b0, 1'b1);

        // Reset while in the middle of the mix.
        start = 1'b1; len = 32'd13; initval = $urandom;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) feed_word(i, 1'b0, w);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midmix_rst_busy", {31'd0, busy}, 32'd0);
        check("midmix_rst_a", out_a, 32'd0);
        check("midmix_rst_b", out_b, 32'd0);
        check("midmix_rst_c", out_c, 32'd0);
        check("midmix_rst_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) kb[i] = 8'($urandom);
        run_key(4, $urandom, 1, 1'b0, 1'b0);

        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < 128; i++) kb[i] = 8'($urandom);
            run_key($urandom_range(1, 100), $urandom, $urandom_range(0, 3), r[0], r[1]);
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
